// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalized floating-point product to nearest-even
// and packs it into a 1+EXP+MANT result, with special-case handling.
// Two-stage pipeline: stage R holds the rounded fields and stage P holds the
// packed result and flags. Both stages use valid/ready handshaking.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   in_valid / in_ready         input beat handshake
//   sign_in, mant_in, exp_in    normalized product (mant_in[MANT] = hidden bit)
//   over_flow_in                exponent overflow already detected upstream
//   spe_case_a_in/_b_in         operand classes
//   discard_in                  shifted-out bits (discard_in[MANT] = guard)
//   out_valid / out_ready       output handshake
//   result                      packed result
//   flags                       {invalid, overflow, underflow, inexact} of result
//   clr_flags, sticky_flags     sticky flag accumulator and its clear
module fp_round_pack #(
    parameter int DW   = 16,
    parameter int EXP  = 5,
    parameter int MANT = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sign_in,
    input  logic [MANT:0]   mant_in,
    input  logic [EXP-1:0]  exp_in,
    input  logic            over_flow_in,
    input  logic [2:0]      spe_case_a_in,
    input  logic [2:0]      spe_case_b_in,
    input  logic [MANT:0]   discard_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   result,
    output logic [3:0]      flags,
    input  logic            clr_flags,
    output logic [3:0]      sticky_flags
);

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'b000,
        CLS_DENORM = 3'b001,
        CLS_ZERO   = 3'b010,
        CLS_INF    = 3'b011,
        CLS_NAN    = 3'b100
    } cls_t;

    // ---------------- rounding (feeds stage R) ----------------
    logic              g_bit, s_bit, rnd_up, carry, exp_zero, inc;
    logic [MANT+1:0]   mant_r;
    logic [MANT:0]     mant_f;
    logic [EXP:0]      exp_adj;
    logic              inx_c, uf_c, ovf_c;

    always_comb begin
        g_bit    = discard_in[MANT];
        s_bit    = |discard_in[MANT-1:0];
        rnd_up   = g_bit & (s_bit | mant_in[0]);
        mant_r   = {1'b0, mant_in} + {{(MANT+1){1'b0}}, rnd_up};
        carry    = mant_r[MANT+1];
        mant_f   = carry ? mant_r[MANT+1:1] : mant_r[MANT:0];
        exp_zero = (exp_in == '0);
        // A denormal input that rounds up into the hidden bit becomes the
        // smallest normal; a carry always bumps the exponent. Both cases
        // coincide when exp_in is zero, so a single +1 covers them.
        inc      = carry | (exp_zero & mant_f[MANT]);
        exp_adj  = {1'b0, exp_in} + {{EXP{1'b0}}, inc};
        inx_c    = g_bit | s_bit;
        uf_c     = exp_zero & ~mant_f[MANT] & inx_c;
        ovf_c    = over_flow_in | exp_adj[EXP] | (&exp_adj[EXP-1:0]);
    end

    // ---------------- pipeline control ----------------
    logic v_r, v_p, load_p;

    assign load_p    = ~v_p | out_ready;
    assign in_ready  = ~v_r | load_p;
    assign out_valid = v_p;

    // ---------------- stage R ----------------
    logic              r_sign, r_ovf, r_uf, r_inx;
    logic [EXP-1:0]    r_exp;
    logic [MANT-1:0]   r_frac;
    logic [2:0]        r_cls_a, r_cls_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r     <= 1'b0;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
            r_uf    <= 1'b0;
            r_inx   <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_cls_a <= '0;
            r_cls_b <= '0;
        end else if (in_ready) begin
            v_r <= in_valid;
            if (in_valid) begin
                r_sign  <= sign_in;
                r_ovf   <= ovf_c;
                r_uf    <= uf_c;
                r_inx   <= inx_c;
                r_exp   <= exp_adj[EXP-1:0];
                r_frac  <= mant_f[MANT-1:0];
                r_cls_a <= spe_case_a_in;
                r_cls_b <= spe_case_b_in;
            end
        end
    end

    // ---------------- pack / special cases ----------------
    logic            any_nan, any_inf, any_zero;
    logic [DW-1:0]   p_result_nx;
    logic [3:0]      p_flags_nx, new_flags;

    always_comb begin
        any_nan  = (r_cls_a == CLS_NAN)  | (r_cls_b == CLS_NAN);
        any_inf  = (r_cls_a == CLS_INF)  | (r_cls_b == CLS_INF);
        any_zero = (r_cls_a == CLS_ZERO) | (r_cls_b == CLS_ZERO);
        p_result_nx = {r_sign, r_exp, r_frac};
        p_flags_nx  = {1'b0, 1'b0, r_uf, r_inx};
        if (any_nan | (any_inf & any_zero)) begin
            p_result_nx = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
            p_flags_nx  = 4'b1000;
        end else if (any_inf) begin
            p_result_nx = {r_sign, {EXP{1'b1}}, {MANT{1'b0}}};
            p_flags_nx  = 4'b0000;
        end else if (any_zero) begin
            p_result_nx = {r_sign, {EXP{1'b0}}, {MANT{1'b0}}};
            p_flags_nx  = 4'b0000;
        end else if (r_ovf) begin
            p_result_nx = {r_sign, {EXP{1'b1}}, {MANT{1'b0}}};
            p_flags_nx  = 4'b0101;
        end
        new_flags = (load_p & v_r) ? p_flags_nx : 4'b0000;
    end

    // ---------------- stage P ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_p          <= 1'b0;
            result       <= '0;
            flags        <= '0;
            sticky_flags <= '0;
        end else begin
            if (load_p) begin
                v_p <= v_r;
                if (v_r) begin
                    result <= p_result_nx;
                    flags  <= p_flags_nx;
                end
            end
            // Flags arriving on the clearing edge survive the clear.
            sticky_flags <= clr_flags ? new_flags : (sticky_flags | new_flags);
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [10:0] mant_in;
    logic [4:0]  exp_in;
    logic        over_flow_in;
    logic [2:0]  spe_case_a_in;
    logic [2:0]  spe_case_b_in;
    logic [10:0] discard_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        clr_flags;
    logic [3:0]  sticky_flags;

    int tests = 0;
    int fails = 0;

    fp_round_pack #(.DW(16), .EXP(5), .MANT(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .mant_in(mant_in), .exp_in(exp_in),
        .over_flow_in(over_flow_in),
        .spe_case_a_in(spe_case_a_in), .spe_case_b_in(spe_case_b_in),
        .discard_in(discard_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic s, input logic [10:0] m, input logic [4:0] e,
                            input logic o, input logic [2:0] ca, input logic [2:0] cb,
                            input logic [10:0] d);
        sign_in = s; mant_in = m; exp_in = e; over_flow_in = o;
        spe_case_a_in = ca; spe_case_b_in = cb; discard_in = d;
    endtask

    // Sends one beat with out_ready high, returns the result, flags and the
    // number of edges from the accepting edge (inclusive) to out_valid.
    task automatic send(input logic s, input logic [10:0] m, input logic [4:0] e,
                        input logic o, input logic [2:0] ca, input logic [2:0] cb,
                        input logic [10:0] d,
                        output logic [15:0] r, output logic [3:0] f, output int lat);
        int n;
        set_beat(s, m, e, o, ca, cb, d);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin tick(); lat++; end
        r = result;
        f = flags;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
        set_beat(1'b0, 11'h0, 5'h0, 1'b0, 3'b000, 3'b000, 11'h0);
        tick(); tick();
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (result !== 16'h0) begin fails++; $display("FAIL reset_result got %h want 0000", result); end
        tests++; if (flags !== 4'h0) begin fails++; $display("FAIL reset_flags got %b want 0000", flags); end
        tests++; if (sticky_flags !== 4'h0) begin fails++; $display("FAIL reset_sticky got %b want 0000", sticky_flags); end
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h480, 5'd16, 1'b0, 3'b000, 3'b000, 11'h0, r, f, lat);
        tests++; if (r !== 16'h4080) begin fails++; $display("FAIL basic_result got %h want 4080", r); end
        tests++; if (f !== 4'b0000) begin fails++; $display("FAIL basic_flags got %b want 0000", f); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL basic_latency got %0d want 2", lat); end
    endtask

    task automatic test_round();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h401, 5'd15, 1'b0, 3'b000, 3'b000, 11'h400, r, f, lat);
        tests++; if (r !== 16'h3C02) begin fails++; $display("FAIL tie_odd_result got %h want 3c02", r); end
        tests++; if (f !== 4'b0001) begin fails++; $display("FAIL tie_odd_flags got %b want 0001", f); end
        send(1'b0, 11'h400, 5'd15, 1'b0, 3'b000, 3'b000, 11'h400, r, f, lat);
        tests++; if (r !== 16'h3C00) begin fails++; $display("FAIL tie_even_result got %h want 3c00", r); end
        tests++; if (f !== 4'b0001) begin fails++; $display("FAIL tie_even_flags got %b want 0001", f); end
        send(1'b0, 11'h7FF, 5'd15, 1'b0, 3'b000, 3'b000, 11'h600, r, f, lat);
        tests++; if (r !== 16'h4000) begin fails++; $display("FAIL carry_result got %h want 4000", r); end
        tests++; if (f !== 4'b0001) begin fails++; $display("FAIL carry_flags got %b want 0001", f); end
    endtask

    task automatic test_overflow();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h7FF, 5'd30, 1'b0, 3'b000, 3'b000, 11'h600, r, f, lat);
        tests++; if (r !== 16'h7C00) begin fails++; $display("FAIL ovf_round_result got %h want 7c00", r); end
        tests++; if (f !== 4'b0101) begin fails++; $display("FAIL ovf_round_flags got %b want 0101", f); end
        tests++; if (sticky_flags[2] !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", sticky_flags[2]); end
        send(1'b1, 11'h400, 5'd15, 1'b1, 3'b000, 3'b000, 11'h0, r, f, lat);
        tests++; if (r !== 16'hFC00) begin fails++; $display("FAIL ovf_in_result got %h want fc00", r); end
        tests++; if (f !== 4'b0101) begin fails++; $display("FAIL ovf_in_flags got %b want 0101", f); end
    endtask

    task automatic test_underflow();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h0FF, 5'd0, 1'b0, 3'b001, 3'b000, 11'h400, r, f, lat);
        tests++; if (r !== 16'h0100) begin fails++; $display("FAIL uf_denorm_result got %h want 0100", r); end
        tests++; if (f !== 4'b0011) begin fails++; $display("FAIL uf_denorm_flags got %b want 0011", f); end
        send(1'b0, 11'h3FF, 5'd0, 1'b0, 3'b001, 3'b000, 11'h600, r, f, lat);
        tests++; if (r !== 16'h0400) begin fails++; $display("FAIL uf_promote_result got %h want 0400", r); end
        tests++; if (f !== 4'b0001) begin fails++; $display("FAIL uf_promote_flags got %b want 0001", f); end
    endtask

    task automatic test_special();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h480, 5'd16, 1'b0, 3'b011, 3'b010, 11'h0, r, f, lat);
        tests++; if (r !== 16'h7E00) begin fails++; $display("FAIL inf_zero_result got %h want 7e00", r); end
        tests++; if (f !== 4'b1000) begin fails++; $display("FAIL inf_zero_flags got %b want 1000", f); end
        send(1'b1, 11'h480, 5'd16, 1'b0, 3'b100, 3'b011, 11'h0, r, f, lat);
        tests++; if (r !== 16'h7E00) begin fails++; $display("FAIL nan_result got %h want 7e00", r); end
        send(1'b1, 11'h480, 5'd16, 1'b0, 3'b000, 3'b011, 11'h7FF, r, f, lat);
        tests++; if (r !== 16'hFC00) begin fails++; $display("FAIL inf_result got %h want fc00", r); end
        tests++; if (f !== 4'b0000) begin fails++; $display("FAIL inf_flags got %b want 0000", f); end
        send(1'b1, 11'h480, 5'd16, 1'b0, 3'b010, 3'b000, 11'h400, r, f, lat);
        tests++; if (r !== 16'h8000) begin fails++; $display("FAIL zero_result got %h want 8000", r); end
        tests++; if (f !== 4'b0000) begin fails++; $display("FAIL zero_flags got %b want 0000", f); end
        send(1'b0, 11'h480, 5'd16, 1'b0, 3'b101, 3'b111, 11'h0, r, f, lat);
        tests++; if (r !== 16'h4080) begin fails++; $display("FAIL odd_class_result got %h want 4080", r); end
        tests++; if (sticky_flags !== 4'b1111) begin fails++; $display("FAIL sticky_accum got %b want 1111", sticky_flags); end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++; if (sticky_flags !== 4'b0000) begin fails++; $display("FAIL sticky_clear got %b want 0000", sticky_flags); end
    endtask

    task automatic test_clr_same_cycle();
        logic [15:0] r; logic [3:0] f; int lat;
        send(1'b0, 11'h480, 5'd16, 1'b0, 3'b100, 3'b000, 11'h0, r, f, lat);
        tests++; if (sticky_flags !== 4'b1000) begin fails++; $display("FAIL clr_pre_sticky got %b want 1000", sticky_flags); end
        set_beat(1'b0, 11'h7FF, 5'd30, 1'b0, 3'b000, 3'b000, 11'h600);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++; if (sticky_flags !== 4'b0101) begin fails++; $display("FAIL clr_same_cycle got %b want 0101", sticky_flags); end
        tests++; if (result !== 16'h7C00) begin fails++; $display("FAIL clr_same_result got %h want 7c00", result); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] got [$];
        int idx;
        logic acc;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_beat(1'b0, 11'h400 + 11'(idx), 5'd16, 1'b0, 3'b000, 3'b000, 11'h0);
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        tests++; if (idx !== 2) begin fails++; $display("FAIL bp_accepted got %0d want 2", idx); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        tests++; if (result !== 16'h4000) begin fails++; $display("FAIL bp_hold got %h want 4000", result); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            in_valid = (idx < 3);
            set_beat(1'b0, 11'h400 + 11'(idx), 5'd16, 1'b0, 3'b000, 3'b000, 11'h0);
            acc = in_valid && in_ready;
            if (out_valid) got.push_back(result);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        tests++; if (got.size() !== 3) begin fails++; $display("FAIL bp_count got %0d want 3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                tests++;
                if (got[k] !== 16'h4000 + 16'(k)) begin
                    fails++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], 16'h4000 + 16'(k));
                end
            end
        end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_extra got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        out_ready = 1'b0;
        set_beat(1'b0, 11'h7FF, 5'd30, 1'b0, 3'b000, 3'b000, 11'h600);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        tests++; if (sticky_flags !== 4'b0101) begin fails++; $display("FAIL mid_pre_sticky got %b want 0101", sticky_flags); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", out_valid); end
        tests++; if (sticky_flags !== 4'b0000) begin fails++; $display("FAIL mid_sticky got %b want 0000", sticky_flags); end
        tests++; if (result !== 16'h0) begin fails++; $display("FAIL mid_result got %h want 0000", result); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_stale got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_overflow();
        test_underflow();
        test_special();
        test_clr_same_cycle();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 SHALL have parameter DW, default 16, total result width; DW SHALL equal 1+EXP+MANT.
REQ-002 SHALL have parameter EXP, default 5, exponent field width.
REQ-003 SHALL have parameter MANT, default 10, stored fraction width.
REQ-004 SHALL have ports as follows, one clock, reset synchronous active-low:
 clk  in  1  system clock, all state on rising edge
 rst_n  in  1  synchronous active-low reset
 in_valid  in  1  normalized-product beat present
 in_ready  out  1  block accepts beat this cycle
 sign_in  in  1  product sign
 mant_in  in  MANT+1  normalized mantissa, bit MANT = hidden bit
 exp_in  in  EXP  biased exponent
 over_flow_in  in  1  exponent overflow from upstream
 spe_case_a_in / spe_case_b_in  in  3 each  operand class
 discard_in  in  MANT+1  shifted-out bits, bit MANT = guard
 out_valid  out  1  packed result present
 out_ready  in  1  downstream accepts result
 result  out  DW  packed IEEE-style result
 flags  out  4  per-result {invalid, overflow, underflow, inexact}
 clr_flags  in  1  clear sticky flags
 sticky_flags  out  4  accumulated flags, same bit order

Function
REQ-005 Class encoding: 000 normal, 001 denormal, 010 zero, 011 infinity, 100 NaN; other codes treated as normal.
REQ-006 Two pipeline registers: stage R (round) and stage P (pack/output); latency exactly 2 cycles from accepted beat to out_valid when out_ready held high.
REQ-007 Beat accepted on in_valid & in_ready; result consumed on out_valid & out_ready.
REQ-008 in_ready = !vR | !vP | out_ready (vR, vP = stage valid bits); no beat lost or duplicated; order preserved.
REQ-009 Stage P loads from R when !vP or out_ready; P holds result/flags stable while out_valid & !out_ready.
REQ-010 Full throughput: one beat per cycle when out_ready high.
REQ-011 Rounding round-to-nearest-even: G = discard_in[MANT], S = OR of discard_in[MANT-1:0], L = mant_in[0]; round_up = G & (S | L).
REQ-012 mant_r = mant_in + round_up at MANT+2 bits; on carry (bit MANT+1) mantissa = mant_r >> 1, exponent += 1.
REQ-013 exp_in = 0 with rounded hidden bit 1 SHALL give exponent field 1; hidden bit 0 SHALL give exponent field 0 and underflow = inexact.
REQ-014 inexact = G | S for computed results; 0 for special-case results.
REQ-015 Overflow: over_flow_in set, or final exponent all-ones -> result = signed infinity, overflow=1, inexact=1.
REQ-016 Special-case priority (highest first): any NaN, or infinity with zero -> quiet NaN {0, all-ones exp, fraction MSB 1, rest 0}, invalid=1; any infinity -> {sign_in, all-ones, 0}; any zero -> {sign_in, 0, 0}; else computed.
REQ-017 sticky_flags bit set when a result with that flag is registered into stage P; bits never clear except by clr_flags or reset.
REQ-018 clr_flags same cycle as new flag load: new flag bits SHALL be set, others cleared.

Reset
REQ-019 rst_n low at clock edge: vR, vP, out_valid, result, flags, sticky_flags SHALL be 0; in_ready SHALL read 1 from first cycle after reset.
REQ-020 Reset mid-operation discards in-flight beats; no result emitted for them.

Verification (DW=16, EXP=5, MANT=10)
REQ-021 exp_in=16, mant_in=11'h480, discard_in=0, normal classes -> result 16'h4080, flags 0, out_valid 2 cycles after accept.
REQ-022 exp_in=15, mant_in=11'h401, discard_in=11'h400 -> 16'h3C02, inexact=1; mant_in=11'h400 same discard -> 16'h3C00, inexact=1.
REQ-023 exp_in=15, mant_in=11'h7FF, discard_in=11'h600 -> 16'h4000; exp_in=30 same -> 16'h7C00, overflow=1, sticky_flags overflow set.
REQ-024 spe_case_a=011, spe_case_b=010 -> 16'h7E00, invalid=1; then clr_flags pulse -> sticky_flags 0.
REQ-025 out_ready low 4 cycles, in_valid high with 3 beats -> in_ready low after 2 accepted; on release, results emerge in order, none lost.
REQ-026 rst_n low while vR=vP=1 -> next cycle out_valid=0, sticky_flags=0, no stale result after release.
